// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and alignment helper for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, DOUBLE = 2'b11} lsu_size_e;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;

  function automatic logic is_misaligned(input lsu_size_e size, input logic [2:0] ea_low);
    case (size)
      HALF:    return ea_low[0];
      WORD:    return |ea_low[1:0];
      DOUBLE:  return |ea_low;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane placement and load lane extraction/extension
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int LANE_W     = $clog2(BE_WIDTH)
) (
  input  logic [1:0]            st_size,
  input  logic [LANE_W-1:0]     st_lane,
  input  logic [DATA_WIDTH-1:0] st_wdata,
  output logic [BE_WIDTH-1:0]   st_be,
  output logic [DATA_WIDTH-1:0] st_data,
  input  logic [1:0]            ld_size,
  input  logic [LANE_W-1:0]     ld_lane,
  input  logic                  ld_unsigned,
  input  logic [DATA_WIDTH-1:0] ld_rdata,
  output logic [DATA_WIDTH-1:0] ld_data
);

  logic [DATA_WIDTH-1:0] ld_shifted;

  assign ld_shifted = ld_rdata >> {ld_lane, 3'b000};

  // Store data is replicated across every lane so the memory only needs the byte enables.
  always_comb begin
    st_be   = '0;
    st_data = '0;
    case (lsu_size_e'(st_size))
      BYTE: begin
        st_be   = BE_WIDTH'(1) << st_lane;
        st_data = {BE_WIDTH{st_wdata[7:0]}};
      end
      HALF: begin
        st_be   = BE_WIDTH'(3) << st_lane;
        st_data = {(DATA_WIDTH / 16){st_wdata[15:0]}};
      end
      WORD: begin
        st_be   = BE_WIDTH'(15) << st_lane;
        st_data = {(DATA_WIDTH / 32){st_wdata[31:0]}};
      end
      default: begin
        st_be   = '1;
        st_data = st_wdata;
      end
    endcase
  end

  always_comb begin
    ld_data = ld_shifted;
    case (lsu_size_e'(ld_size))
      BYTE:    ld_data = ld_unsigned ? DATA_WIDTH'(ld_shifted[7:0])
                                     : DATA_WIDTH'($signed(ld_shifted[7:0]));
      HALF:    ld_data = ld_unsigned ? DATA_WIDTH'(ld_shifted[15:0])
                                     : DATA_WIDTH'($signed(ld_shifted[15:0]));
      WORD:    ld_data = ld_unsigned ? DATA_WIDTH'(ld_shifted[31:0])
                                     : DATA_WIDTH'($signed(ld_shifted[31:0]));
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - single-outstanding load/store unit driving a req/gnt/rvalid data port
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_size_i,
  input  logic                  lsu_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] offset_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  flush_i,
  output logic                  lsu_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_misaligned_o,
  output logic                  lsu_err_o,
  output logic [ADDR_WIDTH-1:0] lsu_fault_addr_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  input  logic                  data_err_i
);

  localparam int LANE_W = $clog2(BE_WIDTH);

  lsu_state_e            state;
  logic [ADDR_WIDTH-1:0] ea, ea_q;
  logic [1:0]            size_q;
  logic                  we_q, uns_q, kill_q;
  logic                  fault;
  logic [BE_WIDTH-1:0]   st_be;
  logic [DATA_WIDTH-1:0] st_data, ld_data;

  assign ea    = base_i + offset_i;
  assign fault = is_misaligned(lsu_size_e'(lsu_size_i), ea[2:0]) ||
                 (DATA_WIDTH == 32 && lsu_size_e'(lsu_size_i) == DOUBLE);

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .st_size     (lsu_size_i),
    .st_lane     (ea[LANE_W-1:0]),
    .st_wdata    (wdata_i),
    .st_be       (st_be),
    .st_data     (st_data),
    .ld_size     (size_q),
    .ld_lane     (ea_q[LANE_W-1:0]),
    .ld_unsigned (uns_q),
    .ld_rdata    (data_rdata_i),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      ea_q             <= '0;
      size_q           <= '0;
      we_q             <= 1'b0;
      uns_q            <= 1'b0;
      kill_q           <= 1'b0;
      lsu_ready_o      <= 1'b1;
      lsu_rsp_valid_o  <= 1'b0;
      lsu_rdata_o      <= '0;
      lsu_misaligned_o <= 1'b0;
      lsu_err_o        <= 1'b0;
      lsu_fault_addr_o <= '0;
      data_req_o       <= 1'b0;
      data_addr_o      <= '0;
      data_we_o        <= 1'b0;
      data_be_o        <= '0;
      data_wdata_o     <= '0;
    end else begin
      lsu_rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_valid_i) begin
            ea_q        <= ea;
            size_q      <= lsu_size_i;
            we_q        <= lsu_we_i;
            uns_q       <= lsu_unsigned_i;
            kill_q      <= 1'b0;
            lsu_ready_o <= 1'b0;
            if (fault) begin
              state            <= RESP;
              lsu_rsp_valid_o  <= 1'b1;
              lsu_misaligned_o <= 1'b1;
              lsu_err_o        <= 1'b0;
              lsu_rdata_o      <= '0;
              lsu_fault_addr_o <= ea;
            end else begin
              state        <= REQ;
              data_req_o   <= 1'b1;
              data_addr_o  <= {ea[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
              data_we_o    <= lsu_we_i;
              // Loads leave byte enables clear except a full-width double.
              data_be_o    <= (lsu_we_i || lsu_size_e'(lsu_size_i) == DOUBLE) ? st_be : '0;
              data_wdata_o <= lsu_we_i ? st_data : '0;
            end
          end
        end
        REQ: begin
          if (data_gnt_i) begin
            state      <= WAIT;
            data_req_o <= 1'b0;
            kill_q     <= flush_i;
          end else if (flush_i) begin
            state       <= IDLE;
            data_req_o  <= 1'b0;
            lsu_ready_o <= 1'b1;
          end
        end
        WAIT: begin
          if (flush_i) kill_q <= 1'b1;
          // A killed access still has to drain its rvalid before the port is reused.
          if (data_rvalid_i) begin
            if (kill_q || flush_i) begin
              state       <= IDLE;
              lsu_ready_o <= 1'b1;
            end else begin
              state            <= RESP;
              lsu_rsp_valid_o  <= 1'b1;
              lsu_misaligned_o <= 1'b0;
              lsu_err_o        <= data_err_i;
              lsu_rdata_o      <= (we_q || data_err_i) ? '0 : ld_data;
              lsu_fault_addr_o <= ea_q;
            end
          end
        end
        default: begin
          state       <= IDLE;
          lsu_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - randomized bench for lsu_mem_ctrl against a byte-level reference model
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, we, uns, flush, gnt, rvalid, err;
  logic [1:0]  size;
  logic [31:0] base, offset, wdata, rdata;
  logic        ready, rsp_valid, misaligned, bus_err, req, dwe;
  logic [31:0] rsp_rdata, fault_addr, daddr, dwdata;
  logic [3:0]  dbe;

  logic        valid64, we64, uns64, flush64, gnt64, rvalid64, err64;
  logic [1:0]  size64;
  logic [31:0] base64, off64;
  logic [63:0] wdata64, rdata64;
  logic        ready64, rsp_valid64, mis64, err_o64, req64, we_o64;
  logic [63:0] rsp_rdata64, dwdata64;
  logic [31:0] fault64, daddr64;
  logic [7:0]  dbe64;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .lsu_valid_i(valid), .lsu_ready_o(ready), .lsu_we_i(we),
    .lsu_size_i(size), .lsu_unsigned_i(uns), .base_i(base), .offset_i(offset), .wdata_i(wdata),
    .flush_i(flush), .lsu_rsp_valid_o(rsp_valid), .lsu_rdata_o(rsp_rdata),
    .lsu_misaligned_o(misaligned), .lsu_err_o(bus_err), .lsu_fault_addr_o(fault_addr),
    .data_req_o(req), .data_gnt_i(gnt), .data_addr_o(daddr), .data_we_o(dwe), .data_be_o(dbe),
    .data_wdata_o(dwdata), .data_rvalid_i(rvalid), .data_rdata_i(rdata), .data_err_i(err)
  );

  lsu_mem_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
    .clk_i(clk), .rst_i(rst), .lsu_valid_i(valid64), .lsu_ready_o(ready64), .lsu_we_i(we64),
    .lsu_size_i(size64), .lsu_unsigned_i(uns64), .base_i(base64), .offset_i(off64),
    .wdata_i(wdata64), .flush_i(flush64), .lsu_rsp_valid_o(rsp_valid64),
    .lsu_rdata_o(rsp_rdata64), .lsu_misaligned_o(mis64), .lsu_err_o(err_o64),
    .lsu_fault_addr_o(fault64), .data_req_o(req64), .data_gnt_i(gnt64), .data_addr_o(daddr64),
    .data_we_o(we_o64), .data_be_o(dbe64), .data_wdata_o(dwdata64), .data_rvalid_i(rvalid64),
    .data_rdata_i(rdata64), .data_err_i(err64)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte-level view of one access on a bus of nbytes lanes.
  task automatic model(input int nbytes, input logic wr, input logic [1:0] sz, input logic un,
                       input logic [63:0] ea, input logic [63:0] wd, input logic [63:0] rd,
                       output logic mis, output logic [7:0] be, output logic [63:0] bw,
                       output logic [63:0] ld);
    int n, lane;
    n    = 1 << sz;
    lane = int'(ea % 64'(nbytes));
    mis  = (n > nbytes) || (ea % 64'(n) != 0);
    be   = '0;
    bw   = '0;
    ld   = '0;
    for (int i = 0; i < nbytes; i++) begin
      if (wr && i >= lane && i < lane + n) be[i] = 1'b1;
      bw[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    if (!wr && n == 8) be = 8'hFF;
    if (!mis) begin
      for (int i = 0; i < n; i++) ld[8*i +: 8] = rd[8*(lane+i) +: 8];
      if (!un && n < nbytes && ld[8*n-1]) ld = ld - (64'd1 << (8*n));
    end
    if (nbytes == 4) ld[63:32] = '0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("ready_before_accept", ready, 1);
  endtask

  // fmode: 0 normal, 1 flush in REQ before gnt, 2 flush in WAIT
  task automatic do_op(input logic wr, input logic [1:0] sz, input logic un, input logic [31:0] b,
                       input logic [31:0] o, input logic [31:0] wd, input int gdly, input int rdly_in,
                       input logic [31:0] rd, input logic e, input int fmode);
    logic mis;
    logic [7:0] be;
    logic [63:0] bw, ld;
    logic [31:0] ea;
    int rdly;
    rdly = (fmode == 2 && rdly_in == 0) ? 1 : rdly_in;
    ea = b + o;
    model(4, wr, sz, un, {32'd0, ea}, {32'd0, wd}, {32'd0, rd}, mis, be, bw, ld);
    wait_ready();
    valid = 1'b1; we = wr; size = sz; uns = un; base = b; offset = o; wdata = wd;
    @(negedge clk);
    valid = 1'b0; we = 1'($urandom); size = 2'($urandom); base = $urandom; wdata = $urandom;
    if (mis) begin
      check_eq("mis_rsp_valid", rsp_valid, 1);
      check_eq("mis_flag", misaligned, 1);
      check_eq("mis_err", bus_err, 0);
      check_eq("mis_rdata", rsp_rdata, 0);
      check_eq("mis_fault_addr", fault_addr, ea);
      check_eq("mis_no_req", req, 0);
      @(negedge clk);
      check_eq("mis_pulse_end", rsp_valid, 0);
      check_eq("mis_no_req2", req, 0);
      check_eq("mis_ready", ready, 1);
      return;
    end
    for (int i = 0; i <= gdly; i++) begin
      check_eq("req", req, 1);
      check_eq("busy", ready, 0);
      check_eq("addr", daddr, {ea[31:2], 2'b00});
      check_eq("we", dwe, wr);
      check_eq("be", dbe, be[3:0]);
      if (wr) check_eq("wdata", dwdata, bw[31:0]);
      check_eq("no_rsp_req", rsp_valid, 0);
      if (fmode == 1) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_req_drop", req, 0);
        check_eq("flush_req_ready", ready, 1);
        check_eq("flush_req_no_rsp", rsp_valid, 0);
        return;
      end
      gnt = (i == gdly);
      @(negedge clk);
    end
    gnt = 1'b0;
    check_eq("req_drop", req, 0);
    for (int i = 0; i < rdly; i++) begin
      flush = (fmode == 2 && i == 0);
      @(negedge clk);
      flush = 1'b0;
      check_eq("no_rsp_wait", rsp_valid, 0);
    end
    rvalid = 1'b1; rdata = rd; err = e;
    @(negedge clk);
    rvalid = 1'b0; rdata = $urandom; err = 1'b0;
    if (fmode == 2) begin
      check_eq("flush_wait_no_rsp", rsp_valid, 0);
      check_eq("flush_wait_ready", ready, 1);
      return;
    end
    check_eq("rsp_valid", rsp_valid, 1);
    check_eq("rsp_rdata", rsp_rdata, (wr || e) ? 32'd0 : ld[31:0]);
    check_eq("rsp_err", bus_err, e);
    check_eq("rsp_mis", misaligned, 0);
    check_eq("rsp_fault_addr", fault_addr, ea);
    check_eq("rsp_busy", ready, 0);
    @(negedge clk);
    check_eq("rsp_pulse_end", rsp_valid, 0);
    check_eq("ready_after_rsp", ready, 1);
  endtask

  task automatic do_op64(input logic wr, input logic [1:0] sz, input logic un, input logic [31:0] a,
                         input logic [63:0] wd, input logic [63:0] rd);
    logic mis;
    logic [7:0] be;
    logic [63:0] bw, ld;
    model(8, wr, sz, un, {32'd0, a}, wd, rd, mis, be, bw, ld);
    check_eq("r64_ready", ready64, 1);
    valid64 = 1'b1; we64 = wr; size64 = sz; uns64 = un; base64 = a; off64 = '0; wdata64 = wd;
    @(negedge clk);
    valid64 = 1'b0;
    if (mis) begin
      check_eq("r64_mis_rsp", rsp_valid64, 1);
      check_eq("r64_mis_flag", mis64, 1);
      check_eq("r64_mis_no_req", req64, 0);
      @(negedge clk);
      return;
    end
    check_eq("r64_req", req64, 1);
    check_eq("r64_addr", daddr64, {a[31:3], 3'b000});
    check_eq("r64_be", dbe64, be);
    check_eq("r64_we", we_o64, wr);
    if (wr) check_eq("r64_wdata", dwdata64, bw);
    gnt64 = 1'b1;
    @(negedge clk);
    gnt64 = 1'b0; rvalid64 = 1'b1; rdata64 = rd;
    @(negedge clk);
    rvalid64 = 1'b0;
    check_eq("r64_rsp", rsp_valid64, 1);
    check_eq("r64_rdata", rsp_rdata64, wr ? 64'd0 : ld);
    check_eq("r64_err", err_o64, 0);
    check_eq("r64_fault_addr", fault64, a);
    @(negedge clk);
  endtask

  initial begin
    logic        wr, un, e;
    logic [1:0]  sz;
    logic [31:0] ea, b;
    int          fm;
    rst = 1'b1; valid = 1'b0; we = 1'b0; uns = 1'b0; flush = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    err = 1'b0; size = '0; base = '0; offset = '0; wdata = '0; rdata = '0;
    valid64 = 1'b0; we64 = 1'b0; uns64 = 1'b0; flush64 = 1'b0; gnt64 = 1'b0; rvalid64 = 1'b0;
    err64 = 1'b0; size64 = '0; base64 = '0; off64 = '0; wdata64 = '0; rdata64 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_req", req, 0);
    check_eq("rst_rsp", rsp_valid, 0);
    check_eq("rst_be", dbe, 0);
    check_eq("rst_addr", daddr, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op(1'b0, 2'd0, 1'b0, 32'h1000, 32'h3, 32'h0, 0, 0, 32'h80FF_0000, 1'b0, 0);
    do_op(1'b0, 2'd0, 1'b1, 32'h1000, 32'h3, 32'h0, 0, 0, 32'h80FF_0000, 1'b0, 0);
    do_op(1'b1, 2'd1, 1'b0, 32'h2000, 32'h2, 32'h1234_ABCD, 3, 0, 32'h0, 1'b0, 0);
    do_op(1'b0, 2'd2, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h0, 0, 0, 32'h0, 1'b0, 0);
    do_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b1, 0);
    do_op(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 2, 0, 32'h1, 1'b0, 1);
    do_op(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 32'h0, 0, 2, 32'h2, 1'b0, 2);
    do_op(1'b0, 2'd3, 1'b0, 32'h400, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0, 0);

    // Reset while waiting for rvalid; the late rvalid must be dropped.
    wait_ready();
    valid = 1'b1; we = 1'b0; size = 2'd2; base = 32'h40; offset = '0;
    @(negedge clk);
    valid = 1'b0; gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("wrst_ready", ready, 1);
    check_eq("wrst_req", req, 0);
    check_eq("wrst_addr", daddr, 0);
    check_eq("wrst_be", dbe, 0);
    check_eq("wrst_wdata", dwdata, 0);
    check_eq("wrst_we", dwe, 0);
    check_eq("wrst_rsp", rsp_valid, 0);
    check_eq("wrst_fault_addr", fault_addr, 0);
    rvalid = 1'b1; rdata = 32'h5555_5555;
    @(negedge clk);
    rvalid = 1'b0;
    check_eq("stale_rvalid_no_rsp", rsp_valid, 0);
    @(negedge clk);
    check_eq("stale_rvalid_no_rsp2", rsp_valid, 0);
    check_eq("stale_rvalid_ready", ready, 1);

    for (int t = 0; t < 150; t++) begin
      sz = 2'($urandom_range(0, 3));
      wr = 1'($urandom);
      un = 1'($urandom);
      e  = ($urandom_range(0, 7) == 0);
      ea = $urandom;
      if ($urandom_range(0, 3) != 0) ea = ea & ~((32'd1 << sz) - 32'd1);
      b  = $urandom;
      fm = int'($urandom_range(0, 9));
      fm = (fm == 0) ? 1 : (fm == 1) ? 2 : 0;
      do_op(wr, sz, un, b, ea - b, $urandom, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), $urandom, e, fm);
    end

    do_op64(1'b0, 2'd3, 1'b0, 32'h8, 64'h0, 64'h8123_4567_89AB_CDEF);
    do_op64(1'b0, 2'd2, 1'b0, 32'hC, 64'h0, 64'h8765_4321_0000_0000);
    do_op64(1'b1, 2'd2, 1'b0, 32'h4, 64'h0000_0000_CAFE_F00D, 64'h0);
    do_op64(1'b0, 2'd1, 1'b1, 32'h6, 64'h0, 64'hBEEF_0000_0000_0000);
    do_op64(1'b0, 2'd3, 1'b0, 32'h4, 64'h0, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Parametrised load/store unit for the Auriga integer pipeline.
- Takes one memory operation per handshake from the execute stage.
- Computes the effective address as base + offset and checks alignment.
- Drives a req/gnt/rvalid data-memory port and returns extended load data or store completion to writeback.
- Single outstanding transaction. Replaces the combinational address-only stub.

Parameters:
- DATA_WIDTH, 32: data bus width; legal values 32 or 64.
- ADDR_WIDTH, 32: byte address width.
- BE_WIDTH, DATA_WIDTH/8: byte-enable width (derived, not overridden).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- lsu_valid_i  in  1  operation request from execute
- lsu_ready_o  out  1  LSU can accept an operation
- lsu_we_i  in  1  1=store, 0=load
- lsu_size_i  in  2  00 byte, 01 half, 10 word, 11 double
- lsu_unsigned_i  in  1  zero-extend load (LBU/LHU/LWU)
- base_i  in  ADDR_WIDTH  rs1 value
- offset_i  in  ADDR_WIDTH  sign-extended immediate
- wdata_i  in  DATA_WIDTH  store data (rs2), LSB-aligned
- flush_i  in  1  pipeline kill of in-flight operation
- lsu_rsp_valid_o  out  1  one-cycle completion pulse
- lsu_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores/faults
- lsu_misaligned_o  out  1  misaligned/illegal-size fault (with rsp_valid)
- lsu_err_o  out  1  bus access fault (with rsp_valid)
- lsu_fault_addr_o  out  ADDR_WIDTH  effective address of completed op
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory accepted request
- data_addr_o  out  ADDR_WIDTH  bus-word-aligned address (low log2(BE_WIDTH) bits zero)
- data_we_o  out  1  write enable
- data_be_o  out  BE_WIDTH  byte enables
- data_wdata_o  out  DATA_WIDTH  lane-replicated store data
- data_rvalid_i  in  1  response/ack, no earlier than the cycle after gnt
- data_rdata_i  in  DATA_WIDTH  read data
- data_err_i  in  1  bus error, qualified by rvalid

Behaviour:
- Reset (rst_i high at a clock edge, any state): state=IDLE.
  - lsu_ready_o=1.
  - data_req_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0.
  - lsu_rsp_valid_o=0, lsu_rdata_o=0, lsu_misaligned_o=0, lsu_err_o=0, lsu_fault_addr_o=0.
  - In-flight transaction abandoned; a later rvalid is ignored.
- Address: ea = (base_i + offset_i) mod 2^ADDR_WIDTH. lane = ea[log2(BE_WIDTH)-1:0].
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - ready=1.
  - On valid&ready, register ea, we, size, unsigned, and aligned wdata/be.
  - Misaligned (half: ea[0]; word: ea[1:0]!=0; double: ea[2:0]!=0) or size=11 with DATA_WIDTH=32 -> RESP with misaligned=1, no memory access.
  - Otherwise -> REQ.
- REQ:
  - data_req_o=1; addr/we/be/wdata held stable until gnt.
  - gnt -> WAIT.
  - flush_i without gnt in the same cycle -> IDLE, no response.
- WAIT:
  - req=0.
  - On rvalid -> RESP; capture data_err_i and the extracted load data.
  - flush_i in WAIT sets a kill flag: still wait for rvalid, then -> IDLE with no response.
- RESP: lsu_rsp_valid_o=1 for exactly one cycle, ready=0, then -> IDLE.
- Response flags are mutually exclusive: misaligned=1 or err=1 forces lsu_rdata_o=0.
- Store byte enables and data:
  - byte: be=1<<lane, data = wdata[7:0] replicated across all bytes.
  - half: be=0b11<<lane, data = wdata[15:0] replicated.
  - word: be=0xF<<lane, data = wdata[31:0] replicated.
  - double: all ones, data = wdata.
- Load data: byte/half/word taken from lane, sign-extended unless unsigned=1; double passes through.
- Minimum latency: accept at T, req at T+1 (gnt same cycle), rvalid at T+2, rsp_valid at T+3, next accept at T+4.
- Misaligned latency: accept at T, rsp_valid at T+1.
- rvalid outside WAIT is ignored. gnt outside REQ is ignored.

Decomposition:
- lsu_pkg holds:
  - lsu_size_e (BYTE, HALF, WORD, DOUBLE)
  - lsu_state_e (IDLE, REQ, WAIT, RESP)
  - function is_misaligned(size, ea_low)
- One combinational sub-module, lsu_align:
  - store side: produces be/wdata from size, lane and wdata.
  - load side: produces extended rdata from size, lane, unsigned and rdata.
- FSM and registers stay in lsu_mem_ctrl.

Test Plan:
- LB, base=0x1000, off=0x3; memory rdata=0x80FF_0000, gnt immediate, rvalid next cycle -> data_addr_o=0x1000, be=0000 on load; rsp at T+3 with rdata=0xFFFF_FF80. Same access with LBU -> 0x0000_0080.
- SH, base=0x2000, off=0x2, wdata=0x1234_ABCD -> be=1100, data_wdata_o=0xABCD_ABCD, we=1; gnt delayed 3 cycles with addr/be/wdata stable throughout; rsp_valid=1, rdata=0.
- LW, base=0x100, off=-1 (ea=0xFF) -> rsp at T+1, misaligned=1, fault_addr=0xFF, data_req_o never asserted.
- LW to 0x40, rvalid with data_err_i=1 -> rsp: err=1, misaligned=0, rdata=0, fault_addr=0x40.
- flush_i in REQ before gnt -> no rsp, back to IDLE. flush_i in WAIT -> rvalid consumed, no rsp, ready=1 the following cycle.
- rst_i asserted in WAIT -> all outputs 0 and ready=1 next cycle; stale rvalid afterwards produces no rsp. DATA_WIDTH=64 LD at 0x8 -> be=0xFF; size=11 with DATA_WIDTH=32 -> misaligned=1.
